// File: rtl/pipe_pkg.sv
// Shared types and constants for the EXE->MEM pipeline register.
// Occupancy encoding, ctrl bit positions and default field widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  localparam int CTRL_WB_EN = 0;
  localparam int CTRL_MEM_R = 1;
  localparam int CTRL_MEM_W = 2;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_CTRL_W = 3;

endpackage

// File: rtl/pipe_entry.sv
// One payload slot of the EXE->MEM register.
// Load enable, synchronous ctrl clear and asynchronous reset.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_pc,
  input  logic [DATA_W-1:0] d_alu_result,
  input  logic [DATA_W-1:0] d_st_val,
  input  logic [REG_W-1:0]  d_dest,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_pc,
  output logic [DATA_W-1:0] q_alu_result,
  output logic [DATA_W-1:0] q_st_val,
  output logic [REG_W-1:0]  q_dest
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ctrl       <= '0;
      q_pc         <= '0;
      q_alu_result <= '0;
      q_st_val     <= '0;
      q_dest       <= '0;
    end else begin
      if (load) begin
        q_ctrl       <= d_ctrl;
        q_pc         <= d_pc;
        q_alu_result <= d_alu_result;
        q_st_val     <= d_st_val;
        q_dest       <= d_dest;
      end
      // clear wins so a flushed slot never re-issues ctrl
      if (clr) q_ctrl <= '0;
    end
  end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// Elastic EXE->MEM pipeline register with a two-entry skid buffer.
// in_ready depends only on registered occupancy; flush empties both slots.
module exe_mem_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_st_val,
  input  logic [REG_W-1:0]  in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_st_val,
  output logic [REG_W-1:0]  out_dest
);

  occ_t state, state_nx;

  logic accept, pop;
  logic main_ld, skid_ld, main_from_skid;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] skid_pc, skid_alu, skid_st;
  logic [DATA_W-1:0] main_d_pc, main_d_alu, main_d_st;
  logic [REG_W-1:0]  skid_dest, main_d_dest;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_ctrl : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nx = ST_ONE;
          main_ld  = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_ld = 1'b1;
        end else if (accept) begin
          state_nx = ST_FULL;
          skid_ld  = 1'b1;
        end else if (pop) begin
          state_nx = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_nx       = ST_ONE;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
    if (flush) begin
      state_nx = ST_EMPTY;
      main_ld  = 1'b0;
      skid_ld  = 1'b0;
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_pc   = main_from_skid ? skid_pc   : in_pc;
  assign main_d_alu  = main_from_skid ? skid_alu  : in_alu_result;
  assign main_d_st   = main_from_skid ? skid_st   : in_st_val;
  assign main_d_dest = main_from_skid ? skid_dest : in_dest;

  pipe_entry #(
    .DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)
  ) u_main (
    .clk          (clk),
    .rst          (rst),
    .load         (main_ld),
    .clr          (flush),
    .d_ctrl       (main_d_ctrl),
    .d_pc         (main_d_pc),
    .d_alu_result (main_d_alu),
    .d_st_val     (main_d_st),
    .d_dest       (main_d_dest),
    .q_ctrl       (main_ctrl),
    .q_pc         (out_pc),
    .q_alu_result (out_alu_result),
    .q_st_val     (out_st_val),
    .q_dest       (out_dest)
  );

  pipe_entry #(
    .DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .load         (skid_ld),
    .clr          (flush),
    .d_ctrl       (in_ctrl),
    .d_pc         (in_pc),
    .d_alu_result (in_alu_result),
    .d_st_val     (in_st_val),
    .d_dest       (in_dest),
    .q_ctrl       (skid_ctrl),
    .q_pc         (skid_pc),
    .q_alu_result (skid_alu),
    .q_st_val     (skid_st),
    .q_dest       (skid_dest)
  );

endmodule

// File: doc/exe_mem_pipe_reg.md
# exe_mem_pipe_reg

Parametrised, elastic EXE→MEM pipeline register. Carries control bits, PC, ALU result, store value and destination register from the execute stage to the memory stage. Provides a valid/ready handshake with a two-entry skid buffer, so full throughput is kept under back-pressure. A synchronous flush converts in-flight instructions into bubbles.

## Interface
Parameters:
- DATA_W, 32, width of pc, alu_result and st_val fields
- REG_W, 5, width of destination register index
- CTRL_W, 3, control bits: bit0 WB_en, bit1 MEM_R_EN, bit2 MEM_W_EN; higher bits user-defined

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous; discards both entries at next edge
- in_valid  input  1  EXE presents an instruction
- in_ready  output  1  register can accept (registered)
- in_ctrl  input  CTRL_W  control bits
- in_pc  input  DATA_W  PC
- in_alu_result  input  DATA_W  ALU result / memory address
- in_st_val  input  DATA_W  store data
- in_dest  input  REG_W  destination register
- out_valid  output  1  MEM-side instruction present
- out_ready  input  1  MEM stage consumes
- out_ctrl, out_pc, out_alu_result, out_st_val, out_dest  output  same widths  payload of head entry

## Operation
- Storage: main entry (drives outputs) plus skid entry. Each has a valid bit.
- Occupancy state is EMPTY, ONE or FULL.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- Transitions (flush=0):
  - EMPTY: accept → ONE, main←in.
  - ONE: accept&pop → ONE, main←in. accept&!pop → FULL, skid←in. pop&!accept → EMPTY.
  - FULL: pop → ONE, main←skid. No accept possible.
- in_ready = 1 in EMPTY and ONE, 0 in FULL. It is derived from registered state only, never combinationally from out_ready.
- out_valid = main valid.
- out_ctrl is forced to 0 whenever out_valid=0, so a bubble is a NOP to MEM. Other out_* fields hold their last value when invalid.
- Payload order is strictly FIFO; no reordering or duplication.
- Flush:
  - State goes to EMPTY at the next edge; both valid bits and stored ctrl are cleared.
  - An accept in the flush cycle is dropped: flush wins over accept.
  - A pop in the flush cycle still completes, because MEM has already taken it.
- Reset:
  - All outputs 0, including out_valid=0 and the whole payload.
  - in_ready=1; state EMPTY.
  - Asserting rst mid-operation discards both entries immediately, without waiting for a clock edge.

## Timing
- Latency: input accepted at edge N appears on out_* after edge N (available in cycle N+1) when EMPTY or when ONE with a simultaneous pop.
- Throughput: one instruction per cycle while out_ready=1.
- Back-pressure: with out_ready=0, two instructions are absorbed. in_ready falls the cycle after the second accept.
- in_ready rises the cycle after the first pop from FULL.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- Flush: out_valid=0 and in_ready=1 in the cycle after the flush edge.

## Structure
- Shared package pipe_pkg holds:
  - the occupancy enum (ST_EMPTY, ST_ONE, ST_FULL);
  - ctrl bit index constants (CTRL_WB_EN=0, CTRL_MEM_R=1, CTRL_MEM_W=2);
  - default widths.
- One natural sub-module: pipe_entry, a payload register with load enable, sync clear of ctrl and async reset. It is instantiated twice (main, skid).
- State machine and handshake logic live in the top module.

## Test plan
- Reset: hold rst, drive in_valid=1, in_ctrl=3'b111, in_alu_result=32'hDEAD_BEEF → out_valid=0, all out_*=0, in_ready=1. Deassert rst, then one clk → out_alu_result=32'hDEAD_BEEF, out_ctrl=3'b111.
- Streaming: 8 back-to-back inputs with pc=0,4,…,28 and out_ready=1 → outputs pc 0..28 in order, one per cycle, 1-cycle latency, in_ready constantly 1.
- Back-pressure: out_ready=0, send pc=0x100, 0x104, 0x108 → first two accepted, in_ready=0 after the second, 0x108 held upstream. Raise out_ready → 0x100, 0x104, 0x108 delivered in order, none lost.
- Flush: state FULL (pc 0x40, 0x44), then assert flush with in_valid=1, pc=0x48 → next cycle out_valid=0, out_ctrl=0, in_ready=1, and 0x48 never appears.
- Flush with pop: state ONE, out_ready=1 and flush together → entry counted as consumed, next cycle EMPTY.
- Async reset mid-stream: assert rst between clock edges while FULL → out_valid and outputs 0 before the next edge; normal streaming resumes after release.
